// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: redirect opcodes,
// fetch FSM state encoding and the PCoffset9 sign-extension helper.
package fetch_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_JMP = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_t;

  // Sign-extend a 9-bit PC offset; callers truncate to their address width.
  function automatic logic signed [31:0] sext9(input logic [8:0] off);
    return {{23{off[8]}}, off};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue: power-of-two circular buffer with registered storage.
// The head word reads as zero while the queue is empty; clear drops all
// entries and takes priority over push and pop in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear empties the queue at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; data words carry no reset, validity comes from count.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_pq.sv
// LC-3 style fetch unit with a prefetch queue. Issues in-order reads under a
// credit limit (queue occupancy + outstanding reads <= DEPTH), tags each
// response with its address and handles BR/JMP redirects by clearing the
// queue and discarding whatever reads are still in flight.
// Optional build macro FETCH_PERF_EN adds a saturating taken-redirect counter
// on output perf_flush_cnt.
module fetch_pq
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] PC_RESET = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [15:0]       mem_rdata,
  output logic              mem_wea,
  output logic              ir_valid,
  output logic [15:0]       ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_ready,
  input  logic              redir_valid,
  input  logic [3:0]        redir_op,
  input  logic [ADDR_W-1:0] redir_pc,
  input  logic [8:0]        offset_in,
  input  logic [ADDR_W-1:0] reg_in,
  input  logic [2:0]        br_nzp,
  input  logic [2:0]        result_nzp,
  output logic [ADDR_W-1:0] pc
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       perf_flush_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int QW = 16 + ADDR_W;

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     inflight_nxt;
  logic [CW-1:0]     q_count;
  logic              q_full;
  logic              q_empty;
  logic [QW-1:0]     q_rdata;
  logic              redir_vld_p1;
  logic              credit_ok;
  logic              fire;
  logic              rsp;
  logic              push;
  logic              pop;
  logic              is_br;
  logic              taken;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] rsp_addr;

  // Redirect decode: BR is conditional on the nzp match, JMP always taken.
  assign is_br  = (redir_op == OP_BR);
  assign taken  = redir_valid &&
                  ((is_br && (|(br_nzp & result_nzp))) || (redir_op == OP_JMP));
  assign target = is_br ? (redir_pc + ADDR_W'(1) + ADDR_W'(sext9(offset_in)))
                        : reg_in;

  // A response with nothing outstanding is stale (e.g. from before a reset).
  assign fire         = mem_req && mem_gnt;
  assign rsp          = mem_rvalid && (inflight != '0);
  assign inflight_nxt = inflight + CW'(fire) - CW'(rsp);

  // Outside FLUSH the in-flight reads are the consecutive addresses just
  // below pc, so the oldest one sits at pc - inflight.
  assign rsp_addr  = pc - ADDR_W'(inflight);
  assign push      = rsp && (state != ST_FLUSH) && !taken;
  assign pop       = ir_valid && ir_ready;
  assign credit_ok = ({1'b0, q_count} + {1'b0, inflight}) < (CW + 1)'(DEPTH);

  assign mem_addr = pc;
  assign mem_wea  = 1'b0;
  assign ir_valid = !q_empty;
  assign ir_data  = q_rdata[QW-1:ADDR_W];
  assign ir_pc    = q_rdata[ADDR_W-1:0];

  fetch_fifo #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (taken),
    .wdata ({mem_rdata, rsp_addr}),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state; a taken redirect overrides the normal transitions.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (fetch_start) state_nxt = ST_RUN;
      ST_RUN:   if (!fetch_start && (inflight_nxt == '0)) state_nxt = ST_IDLE;
      ST_FLUSH: if (inflight_nxt == '0) state_nxt = fetch_start ? ST_RUN : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (taken) state_nxt = (inflight_nxt != '0) ? ST_FLUSH : ST_RUN;
  end

  // FSM outputs: request only in RUN, with credit, and not right after a redirect.
  always_comb begin
    mem_req = 1'b0;
    if ((state == ST_RUN) && fetch_start && !redir_vld_p1 && !q_full && credit_ok)
      mem_req = 1'b1;
  end

  // Fetch PC, in-flight read count and the one-cycle post-redirect request hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= PC_RESET;
      inflight     <= '0;
      redir_vld_p1 <= 1'b0;
    end else begin
      inflight     <= inflight_nxt;
      redir_vld_p1 <= taken;
      if (taken)     pc <= target;
      else if (fire) pc <= pc + ADDR_W'(1);
    end
  end

`ifdef FETCH_PERF_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Taken-redirect counter, sticking at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        perf_flush_cnt <= '0;
    else if (taken) perf_flush_cnt <= sat_inc16(perf_flush_cnt);
  end
`endif

endmodule

// File: tb/tb_fetch_pq.sv
// Bench for fetch_pq: a memory responder plus a transaction-level model
// (expected next request address, expected next decoded PC, queue occupancy
// and the list of in-flight reads with a drop flag).
module tb_fetch_pq;

  localparam int          DEPTH    = 4;
  localparam logic [15:0] PC_RESET = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_start = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        mem_wea;
  logic        ir_valid;
  logic [15:0] ir_data;
  logic [15:0] ir_pc;
  logic        ir_ready = 1'b0;
  logic        redir_valid = 1'b0;
  logic [3:0]  redir_op = '0;
  logic [15:0] redir_pc = '0;
  logic [8:0]  offset_in = '0;
  logic [15:0] reg_in = '0;
  logic [2:0]  br_nzp = '0;
  logic [2:0]  result_nzp = '0;
  logic [15:0] pc;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_flush_cnt;
`endif

  fetch_pq dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_start (fetch_start),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .mem_wea     (mem_wea),
    .ir_valid    (ir_valid),
    .ir_data     (ir_data),
    .ir_pc       (ir_pc),
    .ir_ready    (ir_ready),
    .redir_valid (redir_valid),
    .redir_op    (redir_op),
    .redir_pc    (redir_pc),
    .offset_in   (offset_in),
    .reg_in      (reg_in),
    .br_nzp      (br_nzp),
    .result_nzp  (result_nzp),
`ifdef FETCH_PERF_EN
    .perf_flush_cnt (perf_flush_cnt),
`endif
    .pc          (pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    bit          drop;
  } rsp_t;

  rsp_t        rsp_q[$];
  logic [15:0] pop_log[$];
  int          checks = 0;
  int          failures = 0;
  int          occ = 0;
  int          grants = 0;
  int          ghost_n = 0;
  int          gnt_pct = 0;
  int          rv_pct = 0;
  int          rdy_pct = 0;
  bit          chk_after = 0;
  logic [15:0] exp_req_pc = PC_RESET;
  logic [15:0] exp_next_pc = PC_RESET;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [15:0] instr(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic bit model_taken(input logic [3:0] op, input logic [2:0] m,
                                     input logic [2:0] c);
    if (op == 4'b1100) return 1'b1;
    if (op == 4'b0000) return (m & c) != 3'b000;
    return 1'b0;
  endfunction

  function automatic logic [15:0] model_target(input logic [3:0] op, input logic [15:0] bpc,
                                               input logic [8:0] off, input logic [15:0] rv);
    int s;
    if (op == 4'b1100) return rv;
    s = off[8] ? int'(off) - 512 : int'(off);
    return 16'(int'(bpc) + 1 + s);
  endfunction

  task automatic model_reset();
    rsp_q.delete();
    occ = 0;
    exp_req_pc = PC_RESET;
    exp_next_pc = PC_RESET;
    chk_after = 0;
  endtask

  // One clock cycle: drive responder/decoder inputs, check, update the model.
  task automatic step();
    bit          from_q;
    bit          req_s;
    bit          popped;
    bit          tk;
    logic [15:0] tgt;
    rsp_t        e;
    mem_gnt    = ($urandom_range(99) < gnt_pct);
    ir_ready   = ($urandom_range(99) < rdy_pct);
    mem_rvalid = 1'b0;
    mem_rdata  = 16'($urandom);
    from_q     = 0;
    if (rsp_q.size() > 0) begin
      if ($urandom_range(99) < rv_pct) begin
        mem_rvalid = 1'b1;
        mem_rdata  = instr(rsp_q[0].addr);
        from_q     = 1;
      end
    end else if (ghost_n > 0 && $urandom_range(99) < rv_pct) begin
      mem_rvalid = 1'b1;
      ghost_n--;
    end
    #1;
    req_s = (mem_req === 1'b1);
    checks++;
    if (pc !== exp_req_pc) begin
      failures++; $display("FAIL pc actual=%h required=%h t=%0t", pc, exp_req_pc, $time);
    end
    checks++;
    if (mem_addr !== exp_req_pc) begin
      failures++; $display("FAIL mem_addr actual=%h required=%h t=%0t", mem_addr, exp_req_pc, $time);
    end
    checks++;
    if (ir_valid !== (occ != 0)) begin
      failures++; $display("FAIL ir_valid actual=%b required=%b t=%0t", ir_valid, occ != 0, $time);
    end
    checks++;
    if (mem_wea !== 1'b0) begin
      failures++; $display("FAIL mem_wea actual=%b required=0", mem_wea);
    end
    checks++;
    if (req_s && (occ + rsp_q.size() >= DEPTH)) begin
      failures++; $display("FAIL credit mem_req actual=1 required=0 occ=%0d inflight=%0d t=%0t",
                           occ, rsp_q.size(), $time);
    end
    if (chk_after) begin
      checks++;
      if (mem_req !== 1'b0) begin
        failures++; $display("FAIL req_after_redirect actual=%b required=0 t=%0t", mem_req, $time);
      end
      chk_after = 0;
    end
    popped = (ir_valid === 1'b1) && ir_ready;
    if (popped) begin
      checks++;
      if (ir_pc !== exp_next_pc) begin
        failures++; $display("FAIL ir_pc actual=%h required=%h t=%0t", ir_pc, exp_next_pc, $time);
      end
      checks++;
      if (ir_data !== instr(exp_next_pc)) begin
        failures++; $display("FAIL ir_data actual=%h required=%h t=%0t", ir_data, instr(exp_next_pc), $time);
      end
      pop_log.push_back(ir_pc);
      exp_next_pc = exp_next_pc + 16'd1;
    end
    tk  = redir_valid && model_taken(redir_op, br_nzp, result_nzp);
    tgt = model_target(redir_op, redir_pc, offset_in, reg_in);
    @(posedge clk);
    if (from_q) begin
      e = rsp_q.pop_front();
      if (!e.drop && !tk) occ++;
    end
    if (popped) occ--;
    if (req_s && mem_gnt) begin
      rsp_q.push_back('{addr: exp_req_pc, drop: tk});
      exp_req_pc = exp_req_pc + 16'd1;
      grants++;
    end
    if (tk) begin
      foreach (rsp_q[i]) rsp_q[i].drop = 1;
      occ = 0;
      exp_req_pc = tgt;
      exp_next_pc = tgt;
      chk_after = 1;
    end
    @(negedge clk);
  endtask

  task automatic redirect(input logic [3:0] op, input logic [15:0] bpc, input logic [8:0] off,
                          input logic [2:0] m, input logic [2:0] c, input logic [15:0] rv);
    redir_valid = 1'b1;
    redir_op    = op;
    redir_pc    = bpc;
    offset_in   = off;
    br_nzp      = m;
    result_nzp  = c;
    reg_in      = rv;
    step();
    redir_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fetch_start = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    ir_ready = 1'b0; redir_valid = 1'b0;
    repeat (5) @(negedge clk);
    model_reset();
    ghost_n = 0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL rst_pc actual=%h required=0000", pc); end
    checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL rst_mem_addr actual=%h required=0000", mem_addr); end
    checks++; if (mem_wea !== 1'b0) begin failures++; $display("FAIL rst_mem_wea actual=%b required=0", mem_wea); end
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL rst_ir_valid actual=%b required=0", ir_valid); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req actual=%b required=0", mem_req); end
    checks++; if (ir_data !== 16'h0000) begin failures++; $display("FAIL rst_ir_data actual=%h required=0000", ir_data); end
    checks++; if (ir_pc !== 16'h0000) begin failures++; $display("FAIL rst_ir_pc actual=%h required=0000", ir_pc); end
    model_reset();
    rst = 1'b0;
    gnt_pct = 0; rv_pct = 0; rdy_pct = 0;
    repeat (2) step();
  endtask

  task automatic test_stream();
    pop_log.delete();
    fetch_start = 1'b1;
    gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
    for (int i = 0; i < 40 && pop_log.size() < 4; i++) step();
    checks++;
    if (pop_log.size() < 4) begin
      failures++; $display("FAIL stream_timeout actual=%0d pops required=4", pop_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pop_log[i] !== 16'(i)) begin
          failures++; $display("FAIL stream_pc%0d actual=%h required=%h", i, pop_log[i], 16'(i));
        end
      end
    end
  endtask

  task automatic test_credit();
    do_reset();
    grants = 0;
    fetch_start = 1'b1;
    gnt_pct = 100; rv_pct = 100; rdy_pct = 0;
    repeat (20) step();
    checks++;
    if (grants != DEPTH) begin
      failures++; $display("FAIL credit_grants actual=%0d required=%0d", grants, DEPTH);
    end
    #1;
    checks++;
    if (mem_req !== 1'b0) begin failures++; $display("FAIL credit_full_req actual=%b required=0", mem_req); end
    pop_log.delete();
    rdy_pct = 100; gnt_pct = 0;
    for (int i = 0; i < 5 && pop_log.size() == 0; i++) step();
    #1;
    checks++;
    if (pop_log.size() == 0 || mem_req !== 1'b1) begin
      failures++; $display("FAIL credit_resume pops=%0d mem_req actual=%b required=1", pop_log.size(), mem_req);
    end
  endtask

  task automatic test_branch();
    do_reset();
    grants = 0;
    fetch_start = 1'b1;
    gnt_pct = 100; rv_pct = 0; rdy_pct = 0;
    for (int i = 0; i < 10 && grants < 2; i++) step();
    gnt_pct = 0;
    redirect(4'b0000, 16'h0005, 9'h1FE, 3'b100, 3'b100, 16'h0000);
    checks++;
    if (pc !== 16'h0004) begin failures++; $display("FAIL br_pc actual=%h required=0004", pc); end
    pop_log.delete();
    gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
    for (int i = 0; i < 30 && pop_log.size() == 0; i++) step();
    checks++;
    if (pop_log.size() == 0 || pop_log[0] !== 16'h0004) begin
      failures++; $display("FAIL br_first_ir_pc actual=%h required=0004 pops=%0d",
                           (pop_log.size() > 0) ? pop_log[0] : 16'hxxxx, pop_log.size());
    end
  endtask

  task automatic test_not_taken();
    logic [15:0] held;
    gnt_pct = 0; rv_pct = 100; rdy_pct = 100;
    repeat (8) step();
    held = exp_req_pc;
    redirect(4'b0000, 16'h0040, 9'h010, 3'b100, 3'b010, 16'h0000);
    checks++;
    if (pc !== held) begin failures++; $display("FAIL brn_not_taken_pc actual=%h required=%h", pc, held); end
    redirect(4'b0001, 16'h0040, 9'h010, 3'b111, 3'b111, 16'h1234);
    checks++;
    if (pc !== held) begin failures++; $display("FAIL other_op_pc actual=%h required=%h", pc, held); end
    redirect(4'b1100, 16'h0040, 9'h000, 3'b000, 3'b000, 16'h3000);
    checks++;
    if (pc !== 16'h3000) begin failures++; $display("FAIL jmp_pc actual=%h required=3000", pc); end
    pop_log.delete();
    gnt_pct = 100;
    for (int i = 0; i < 20 && pop_log.size() == 0; i++) step();
    checks++;
    if (pop_log.size() == 0 || pop_log[0] !== 16'h3000) begin
      failures++; $display("FAIL jmp_first_ir_pc pops=%0d required=3000", pop_log.size());
    end
  endtask

  task automatic test_wrap();
    gnt_pct = 0; rv_pct = 100; rdy_pct = 100;
    repeat (6) step();
    redirect(4'b1100, 16'h0000, 9'h000, 3'b000, 3'b000, 16'hFFFF);
    checks++;
    if (pc !== 16'hFFFF) begin failures++; $display("FAIL wrap_jmp_pc actual=%h required=ffff", pc); end
    grants = 0;
    gnt_pct = 100; rv_pct = 0; rdy_pct = 0;
    for (int i = 0; i < 5 && grants == 0; i++) step();
    #1;
    checks++;
    if (grants != 1 || mem_addr !== 16'h0000) begin
      failures++; $display("FAIL wrap_mem_addr actual=%h required=0000 grants=%0d", mem_addr, grants);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fetch_start = 1'b1;
    gnt_pct = 100; rv_pct = 100; rdy_pct = 0;
    repeat (3) step();
    rv_pct = 0;
    step();
    #2 rst = 1'b1;
    #1;
    checks++; if (pc !== PC_RESET) begin failures++; $display("FAIL midrst_pc actual=%h required=%h", pc, PC_RESET); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL midrst_mem_req actual=%b required=0", mem_req); end
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL midrst_ir_valid actual=%b required=0", ir_valid); end
    checks++; if (mem_addr !== PC_RESET) begin failures++; $display("FAIL midrst_mem_addr actual=%h required=%h", mem_addr, PC_RESET); end
    checks++; if (ir_data !== 16'h0000) begin failures++; $display("FAIL midrst_ir_data actual=%h required=0000", ir_data); end
    ghost_n = rsp_q.size();
    model_reset();
    mem_rvalid = 1'b1; mem_gnt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    rst = 1'b0;
    fetch_start = 1'b0;
    gnt_pct = 0; rv_pct = 100; rdy_pct = 100;
    repeat (6) step();
    checks++;
    if (ghost_n != 0) begin failures++; $display("FAIL midrst_ghosts_left actual=%0d required=0", ghost_n); end
    checks++;
    if (ir_valid !== 1'b0) begin failures++; $display("FAIL midrst_late_rvalid ir_valid actual=%b required=0", ir_valid); end
  endtask

  task automatic test_random();
    do_reset();
    pop_log.delete();
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        gnt_pct = $urandom_range(100, 30);
        rv_pct  = $urandom_range(100, 30);
        rdy_pct = $urandom_range(100, 0);
      end
      fetch_start = ($urandom_range(99) < 95);
      if ($urandom_range(99) < 4) begin
        case ($urandom_range(3))
          0, 1:    redirect(4'b0000, 16'($urandom), 9'($urandom), 3'($urandom), 3'($urandom), 16'($urandom));
          2:       redirect(4'b1100, 16'($urandom), 9'($urandom), 3'($urandom), 3'($urandom), 16'($urandom));
          default: redirect(4'b0001, 16'($urandom), 9'($urandom), 3'b111, 3'b111, 16'($urandom));
        endcase
      end else begin
        step();
      end
    end
    checks++;
    if (pop_log.size() == 0) begin failures++; $display("FAIL random_no_progress actual=0 pops required>0"); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_credit();
    test_branch();
    test_not_taken();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
